// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: next-PC select encoding and
// default reset/exception vectors.
package pc_sequencer_pkg;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_RST  = 3'd0,
        SEL_EXC  = 3'd1,
        SEL_HOLD = 3'd2,
        SEL_RET  = 3'd3,
        SEL_JMP  = 3'd4,
        SEL_BR   = 3'd5,
        SEL_SEQ  = 3'd6
    } pc_sel_t;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; push and pop together act as a pop and flag an error.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             err
);
    import pc_sequencer_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic             err_n;
    logic             do_push;
    logic             empty_q, full_q, err_q;

    // Next pointer/occupancy and error detection for this cycle's request.
    always_comb begin
        ptr_n   = ptr;
        count_n = count;
        err_n   = 1'b0;
        do_push = 1'b0;
        if (pop) begin
            if (count != '0) begin
                ptr_n   = ptr - PTR_W'(1);
                count_n = count - CNT_W'(1);
            end else begin
                err_n = 1'b1;
            end
            if (push) err_n = 1'b1;
        end else if (push) begin
            do_push = 1'b1;
            ptr_n   = ptr + PTR_W'(1);
            if (count == CNT_W'(DEPTH)) err_n = 1'b1;
            else                        count_n = count + CNT_W'(1);
        end
    end

    // Pointer, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr     <= ptr_n;
            count   <= count_n;
            empty_q <= (count_n == '0);
            full_q  <= (count_n == CNT_W'(DEPTH));
            err_q   <= err_n;
        end
    end

    // Entry storage; contents are don't-care while occupancy is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[ptr_n] <= din;
    end

    assign top   = mem[ptr];
    assign empty = empty_q;
    assign full  = full_q;
    assign err   = err_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection, PC register
// and a return-address stack for call/ret.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_tgt,
    input  logic             jump_en,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_tgt,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    // Clears the low log2(STEP) bits so every target is step-aligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP - 1));

    pc_sel_t          sel;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_top;
    logic             active;
    logic             ras_push;
    logic             ras_pop;

    assign pc_seq   = pc + WIDTH'(STEP);
    assign active   = ~rst & ~exc & ~stall;
    assign ras_push = active & call;
    assign ras_pop  = active & ret;

    // Priority select: rst > exc > stall > ret > call/jump > branch > seq.
    always_comb begin
        sel = SEL_SEQ;
        if (rst)                    sel = SEL_RST;
        else if (exc)               sel = SEL_EXC;
        else if (stall)             sel = SEL_HOLD;
        else if (ret)               sel = ras_empty ? SEL_SEQ : SEL_RET;
        else if (call || jump_en)   sel = SEL_JMP;
        else if (branch_en)         sel = SEL_BR;
    end

    // Next-PC mux driven by the select above.
    always_comb begin
        pc_next = pc_seq;
        unique case (sel)
            SEL_RST:  pc_next = RESET_VEC;
            SEL_EXC:  pc_next = EXC_VEC & ALIGN_MASK;
            SEL_HOLD: pc_next = pc;
            SEL_RET:  pc_next = ras_top;
            SEL_JMP:  pc_next = jump_tgt & ALIGN_MASK;
            SEL_BR:   pc_next = branch_tgt & ALIGN_MASK;
            SEL_SEQ:  pc_next = pc_seq;
            default:  pc_next = pc_seq;
        endcase
    end

    // PC register; reset is folded into the select.
    always_ff @(posedge clk) begin
        pc <= pc_next;
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_seq),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .err   (ras_err)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations
// followed by randomized traffic checked against a queue-based model.
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        exc = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_tgt = '0;
    logic        jump_en = 1'b0;
    logic        call = 1'b0;
    logic [31:0] jump_tgt = '0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic        ras_empty, ras_full, ras_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_err;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .exc        (exc),
        .branch_en  (branch_en),
        .branch_tgt (branch_tgt),
        .jump_en    (jump_en),
        .call       (call),
        .jump_tgt   (jump_tgt),
        .ret        (ret),
        .pc         (pc),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_err    (ras_err)
    );

    always #5 clk = ~clk;

    // Model: one architectural step per rising edge.
    always @(posedge clk) begin
        m_err = 1'b0;
        if (rst) begin
            m_pc = 32'h0;
            m_stk.delete();
        end else if (exc) begin
            m_pc = 32'h80;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (call) m_err = 1'b1;
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc  = m_pc + 32'd4;
                m_err = 1'b1;
            end
        end else if (call) begin
            m_stk.push_back(m_pc + 32'd4);
            if (m_stk.size() > DEPTH) begin
                void'(m_stk.pop_front());
                m_err = 1'b1;
            end
            m_pc = {jump_tgt[31:2], 2'b00};
        end else if (jump_en) begin
            m_pc = {jump_tgt[31:2], 2'b00};
        end else if (branch_en) begin
            m_pc = {branch_tgt[31:2], 2'b00};
        end else begin
            m_pc = m_pc + 32'd4;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (pc !== m_pc || ras_empty !== (m_stk.size() == 0) ||
                ras_full !== (m_stk.size() == DEPTH) || ras_err !== m_err) begin
                errors++;
                $display("FAIL model t=%0t: pc=%h empty=%b full=%b err=%b, expected pc=%h empty=%b full=%b err=%b",
                         $time, pc, ras_empty, ras_full, ras_err, m_pc,
                         m_stk.size() == 0, m_stk.size() == DEPTH, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; exc = 0; branch_en = 0; jump_en = 0; call = 0; ret = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_call(input logic [31:0] tgt);
        idle(); call = 1; jump_tgt = tgt; tick(); idle();
    endtask

    task automatic do_ret();
        idle(); ret = 1; tick(); idle();
    endtask

    task automatic do_jump(input logic [31:0] tgt);
        idle(); jump_en = 1; jump_tgt = tgt; tick(); idle();
    endtask

    initial begin
        // Reset, then three idle cycles.
        tick();
        chk_en = 1'b1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_empty", 32'(ras_empty), 32'd1);
        chk("reset_full", 32'(ras_full), 32'd0);
        idle();
        tick(); chk("seq1", pc, 32'h4);
        tick(); chk("seq2", pc, 32'h8);
        tick(); chk("seq3", pc, 32'hC);
        chk("seq_empty", 32'(ras_empty), 32'd1);

        // Call / return round trip.
        tick(); chk("at_10", pc, 32'h10);
        do_call(32'h200); chk("call_pc", pc, 32'h200);
        chk("call_not_empty", 32'(ras_empty), 32'd0);
        tick(); chk("call_seq1", pc, 32'h204);
        tick(); chk("call_seq2", pc, 32'h208);
        do_ret(); chk("ret_pc", pc, 32'h14);
        chk("ret_empty", 32'(ras_empty), 32'd1);

        // Five nested calls against a 4-deep stack.
        do_call(32'h1000);
        do_call(32'h2000);
        do_call(32'h3000);
        chk("full_before", 32'(ras_full), 32'd0);
        do_call(32'h4000);
        chk("full_after4", 32'(ras_full), 32'd1);
        chk("no_err_4", 32'(ras_err), 32'd0);
        do_call(32'h5000);
        chk("overflow_err", 32'(ras_err), 32'd1);
        chk("overflow_full", 32'(ras_full), 32'd1);
        chk("overflow_pc", pc, 32'h5000);
        do_ret(); chk("ret1", pc, 32'h4004);
        chk("ret1_err", 32'(ras_err), 32'd0);
        do_ret(); chk("ret2", pc, 32'h3004);
        do_ret(); chk("ret3", pc, 32'h2004);
        do_ret(); chk("ret4", pc, 32'h1004);
        chk("ret4_empty", 32'(ras_empty), 32'd1);
        do_ret(); chk("underflow_pc", pc, 32'h1008);
        chk("underflow_err", 32'(ras_err), 32'd1);

        // Stall holds over a branch; exc overrides stall.
        do_jump(32'h40); chk("jump_40", pc, 32'h40);
        stall = 1; branch_en = 1; branch_tgt = 32'h300;
        tick(); chk("stall1", pc, 32'h40);
        chk("stall_err", 32'(ras_err), 32'd0);
        tick(); chk("stall2", pc, 32'h40);
        exc = 1;
        tick(); chk("exc_pc", pc, 32'h80);
        idle();

        // Wrap-around and target alignment.
        do_jump(32'hFFFF_FFFC); chk("jump_top", pc, 32'hFFFF_FFFC);
        tick(); chk("wrap", pc, 32'h0);
        branch_en = 1; branch_tgt = 32'h103;
        tick(); chk("align_br", pc, 32'h100);
        idle();

        // call+ret conflict with one entry, then reset.
        do_jump(32'h20);
        do_call(32'h500); chk("one_entry", pc, 32'h500);
        call = 1; ret = 1; jump_tgt = 32'h600;
        tick(); chk("conflict_pc", pc, 32'h24);
        chk("conflict_err", 32'(ras_err), 32'd1);
        chk("conflict_empty", 32'(ras_empty), 32'd1);
        idle(); rst = 1;
        tick(); chk("rst_after", pc, 32'h0);
        chk("rst_err_clr", 32'(ras_err), 32'd0);

        // Reset mid-sequence discards the stack.
        idle();
        do_call(32'h700);
        rst = 1; tick(); idle();
        do_ret(); chk("rst_discard_pc", pc, 32'h4);
        chk("rst_discard_err", 32'(ras_err), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            exc        = ($urandom_range(0, 99) < 5);
            stall      = ($urandom_range(0, 99) < 15);
            ret        = ($urandom_range(0, 99) < 20);
            call       = ($urandom_range(0, 99) < 25);
            jump_en    = ($urandom_range(0, 99) < 10);
            branch_en  = ($urandom_range(0, 99) < 20);
            branch_tgt = $urandom();
            jump_tgt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                     : $urandom();
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
